truth_table_sweeper: RTL and testbench

- Hardware stimulus/response engine for 4-input combinational function blocks, e.g. the F(W,X,Y,Z) = m(0,1,8,9,10,11,12,14,15) dataflow model.
- Drives every input vector 0..15 in order and samples the function output for each one.
- Builds the captured 16-bit truth table and compares it against an expected minterm mask.
- Reports pass/fail, the number of mismatches and the first failing minterm. Replaces the open-loop stimulus loop with a synthesizable self-checking sequencer.

---
 rtl/truth_table_sweeper.sv | 123 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// truth_table_sweeper: sweeps all 16 vectors of a 4-input function, captures
// its truth table and compares it against EXPECTED.        Rev 1.0
// ============================================================================
module truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'hDF03,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic [3:0]  vec_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail,
    output logic        first_fail_valid
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  vec_q, vec_d;
    logic [15:0] captured_q, captured_d;
    logic [4:0]  fail_count_q, fail_count_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        ffv_q, ffv_d;
    logic        pass_q, pass_d;
    logic        mismatch;
    logic        accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            vec_q        <= 4'd0;
            captured_q   <= 16'd0;
            fail_count_q <= 5'd0;
            first_fail_q <= 4'd0;
            ffv_q        <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            captured_q   <= captured_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            ffv_q        <= ffv_d;
            pass_q       <= pass_d;
        end
    end

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
            S_DRIVE:        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE:       state_d = (vec_q == 4'd15) ? S_DONE : S_DRIVE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        captured_d   = captured_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        ffv_d        = ffv_q;
        pass_d       = pass_q;
        mismatch     = (f_in != EXPECTED[vec_q]);
        if (accept) begin
            cnt_d        = 4'd0;
            vec_d        = 4'd0;
            captured_d   = 16'd0;
            fail_count_d = 5'd0;
            first_fail_d = 4'd0;
            ffv_d        = 1'b0;
            pass_d       = 1'b0;
        end else if (state_q == S_DRIVE) begin
            cnt_d = cnt_q + 4'd1;
        end else if (state_q == S_SAMPLE) begin
            captured_d[vec_q] = f_in;
            if (mismatch) begin
                fail_count_d = fail_count_q + 5'd1;
                if (!ffv_q) begin
                    first_fail_d = vec_q;
                    ffv_d        = 1'b1;
                end
            end
            if (vec_q != 4'd15) begin
                vec_d = vec_q + 4'd1;
                cnt_d = 4'd0;
            end else begin
                // verdict includes the vector-15 compare made on this same edge
                pass_d = (fail_count_d == 5'd0);
            end
        end
    end

    always_comb begin
        busy             = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
        done             = (state_q == S_DONE);
        pass             = pass_q;
        vec_out          = vec_q;
        captured         = captured_q;
        fail_count       = fail_count_q;
        first_fail       = first_fail_q;
        first_fail_valid = ffv_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench: sweeps queue their expected verdict, monitors check on done.
module tb_truth_table_sweeper;
    localparam logic [15:0] GOLD = 16'hDF03;

    typedef struct packed {
        logic [15:0] cap;
        logic        pass;
        logic [4:0]  fc;
        logic [3:0]  ff;
        logic        ffv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, f_in, start3, f_in3;
    logic [3:0]  vec_out, first_fail, vec3, first_fail3;
    logic        busy, done, pass, ffv, busy3, done3, pass3, ffv3;
    logic [15:0] captured, captured3;
    logic [4:0]  fail_count, fail_count3;

    int   mode;   // 0 golden, 1 tied 0, 2 inverted, 3 golden with vector 12 forced 0
    int   errors = 0;
    int   checks = 0;
    exp_t q1[$];
    exp_t q3[$];

    truth_table_sweeper #(.EXPECTED(GOLD), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec_out(vec_out),
        .busy(busy), .done(done), .pass(pass), .captured(captured),
        .fail_count(fail_count), .first_fail(first_fail), .first_fail_valid(ffv));

    truth_table_sweeper #(.EXPECTED(GOLD), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .f_in(f_in3), .vec_out(vec3),
        .busy(busy3), .done(done3), .pass(pass3), .captured(captured3),
        .fail_count(fail_count3), .first_fail(first_fail3), .first_fail_valid(ffv3));

    always_comb begin
        case (mode)
            1:       f_in = 1'b0;
            2:       f_in = ~GOLD[vec_out];
            3:       f_in = (vec_out == 4'd12) ? 1'b0 : GOLD[vec_out];
            default: f_in = GOLD[vec_out];
        endcase
        f_in3 = GOLD[vec3];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [15:0] cap,
                           input logic ps, input logic [4:0] fc, input logic [3:0] ff,
                           input logic fv);
        chk({tag, "_captured"}, 64'(cap), 64'(e.cap));
        chk({tag, "_pass"}, 64'(ps), 64'(e.pass));
        chk({tag, "_fail_count"}, 64'(fc), 64'(e.fc));
        chk({tag, "_first_fail"}, 64'(ff), 64'(e.ff));
        chk({tag, "_first_fail_valid"}, 64'(fv), 64'(e.ffv));
    endtask

    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 64'd1, 64'd0);
            else compare("dut1", q1.pop_front(), captured, pass, fail_count, first_fail, ffv);
        end
        done_prev = done;
    end

    logic done3_prev = 1'b0;
    always @(negedge clk) begin
        if (done3 && !done3_prev) begin
            if (q3.size() == 0) chk("dut3_unexpected_done", 64'd1, 64'd0);
            else compare("dut3", q3.pop_front(), captured3, pass3, fail_count3, first_fail3, ffv3);
        end
        done3_prev = done3;
    end

    task automatic sweep1(input exp_t e, input bit push_exp, input bit wait_done);
        int n;
        @(negedge clk);
        if (push_exp) q1.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_clears_status",
            64'({busy, done, pass, captured, fail_count, first_fail, ffv, vec_out}),
            64'({1'b1, 32'd0}));
        if (wait_done) begin
            n = 0;
            while (!done && n < 200) begin
                @(posedge clk);
                #1 n++;
            end
            chk("sweep_latency", 64'(n), 64'd32);
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e_gold, e_zero, e_inv, e_12;
        int n, c, glitch, badrun, runs, run, first_done;
        logic [3:0] prev;
        e_gold = '{cap: 16'hDF03, pass: 1'b1, fc: 5'd0,  ff: 4'd0,  ffv: 1'b0};
        e_zero = '{cap: 16'h0000, pass: 1'b0, fc: 5'd9,  ff: 4'd0,  ffv: 1'b1};
        e_inv  = '{cap: 16'h20FC, pass: 1'b0, fc: 5'd16, ff: 4'd0,  ffv: 1'b1};
        e_12   = '{cap: 16'hCF03, pass: 1'b0, fc: 5'd1,  ff: 4'd12, ffv: 1'b1};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_dut1",
            64'({vec_out, busy, done, pass, captured, fail_count, first_fail, ffv}), 64'd0);
        chk("reset_state_dut3",
            64'({vec3, busy3, done3, pass3, captured3, fail_count3, first_fail3, ffv3}), 64'd0);
        @(negedge clk) rst = 1'b0;

        mode = 0; sweep1(e_gold, 1'b1, 1'b1);
        mode = 1; sweep1(e_zero, 1'b1, 1'b1);
        mode = 2; sweep1(e_inv,  1'b1, 1'b1);
        mode = 0; sweep1(e_gold, 1'b1, 1'b1);
        mode = 3; sweep1(e_12,   1'b1, 1'b1);

        // asynchronous reset mid-sweep, between clock edges
        mode = 0;
        sweep1(e_gold, 1'b0, 1'b0);
        n = 0;
        while (vec_out != 4'd7 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("reach_vec7", 64'(vec_out), 64'd7);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            64'({vec_out, busy, done, pass, captured, fail_count, first_fail, ffv}), 64'd0);
        @(negedge clk) rst = 1'b0;
        sweep1(e_gold, 1'b1, 1'b1);

        // SETTLE=3 instance with start held high for 100 cycles
        @(negedge clk);
        q3.push_back(e_gold);
        q3.push_back(e_gold);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        prev = vec3; run = 1; glitch = 0; badrun = 0; runs = 0; first_done = -1;
        for (c = 1; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (first_done < 0) begin
                if (done3) first_done = c;
                else begin
                    if (!busy3) glitch++;
                    if (vec3 == prev) run++;
                    else begin
                        if (vec3 == prev + 4'd1) begin
                            runs++;
                            if (run != 4) badrun++;
                        end
                        prev = vec3;
                        run  = 1;
                    end
                end
            end else if (c == first_done + 1) begin
                chk("held_start_restart", 64'({busy3, done3, vec3}), 64'({1'b1, 1'b0, 4'd0}));
            end
        end
        start3 = 1'b0;
        chk("settle3_latency", 64'(first_done), 64'd64);
        chk("settle3_busy_glitches", 64'(glitch), 64'd0);
        chk("settle3_bad_holds", 64'(badrun), 64'd0);
        chk("settle3_holds_seen", 64'(runs), 64'd15);
        n = 0;
        while (!done3 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("settle3_second_done", 64'(done3), 64'd1);
        repeat (2) @(negedge clk);

        chk("dut1_queue_drained", 64'(q1.size()), 64'd0);
        chk("dut3_queue_drained", 64'(q3.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
